// File: rtl/kamus_pkg.sv
// kamus_pkg: register-file constants and address type shared by decode,
// writeback and the register file.
//   REG_ADDR_W - width of an architectural register address
//   NUM_REGS   - number of architectural registers (x0..x31)
//   reg_addr_t - architectural register address
package kamus_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;

endpackage

// File: rtl/kamus_regfile_if.sv
// kamus_regfile_if: writeback, read-port and scoreboard signals between the
// pipeline (master: decode + writeback) and the register file (slave).
//   write port : regfile_wr_en_i, rd_addr_i, wb_data_i
//   read ports : rs1_addr_i/rs1_data_o, rs2_addr_i/rs2_data_o
//   scoreboard : issue_en_i, issue_rd_i, flush_i, rs1_busy_o, rs2_busy_o,
//                pending_cnt_o
interface kamus_regfile_if #(
  parameter int unsigned XLEN = 32
) ();
  import kamus_pkg::*;

  logic                  regfile_wr_en_i;
  reg_addr_t             rd_addr_i;
  logic [XLEN-1:0]       wb_data_i;
  reg_addr_t             rs1_addr_i;
  reg_addr_t             rs2_addr_i;
  logic [XLEN-1:0]       rs1_data_o;
  logic [XLEN-1:0]       rs2_data_o;
  logic                  issue_en_i;
  reg_addr_t             issue_rd_i;
  logic                  flush_i;
  logic                  rs1_busy_o;
  logic                  rs2_busy_o;
  logic [REG_ADDR_W:0]   pending_cnt_o;

  modport master (
    output regfile_wr_en_i, rd_addr_i, wb_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o,
    output issue_en_i, issue_rd_i, flush_i,
    input  rs1_busy_o, rs2_busy_o, pending_cnt_o
  );

  modport slave (
    input  regfile_wr_en_i, rd_addr_i, wb_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o,
    input  issue_en_i, issue_rd_i, flush_i,
    output rs1_busy_o, rs2_busy_o, pending_cnt_o
  );

endinterface

// File: rtl/kamus_scoreboard.sv
// kamus_scoreboard: per-register pending-write tracking.
//   clk_i, rst_ni        - clock, async active-low reset
//   issue_en_i/issue_rd_i - decode marks issue_rd_i as having a producer
//   wr_en_i/rd_addr_i     - writeback retires the producer of rd_addr_i
//   flush_i              - drop every outstanding producer
//   rs1/rs2_addr_i        - read addresses to test
//   rs1/rs2_busy_o        - read address still waiting on a producer
//   pending_cnt_o        - registered population count of pending bits
module kamus_scoreboard
  import kamus_pkg::*;
#(
  parameter int unsigned NREGS     = NUM_REGS,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_en_i,
  input  reg_addr_t           issue_rd_i,
  input  logic                wr_en_i,
  input  reg_addr_t           rd_addr_i,
  input  logic                flush_i,
  input  reg_addr_t           rs1_addr_i,
  input  reg_addr_t           rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic [REG_ADDR_W:0] pending_cnt_o
);

  // Bit 0 is never set, which keeps x0 permanently not-busy.
  logic [NREGS-1:0]    pending_q;
  logic [NREGS-1:0]    pending_nxt;
  logic [REG_ADDR_W:0] cnt_nxt;

  // Clear is applied before set so a same-cycle issue to the register being
  // written back wins: the newer producer is the one still outstanding.
  always_comb begin
    pending_nxt = pending_q;
    if (flush_i) begin
      pending_nxt = '0;
    end else begin
      if (wr_en_i && (rd_addr_i != REG_X0)) pending_nxt[rd_addr_i] = 1'b0;
      if (issue_en_i && (issue_rd_i != REG_X0)) pending_nxt[issue_rd_i] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + {{REG_ADDR_W{1'b0}}, pending_nxt[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= '0;
      pending_cnt_o <= '0;
    end else begin
      pending_q     <= pending_nxt;
      pending_cnt_o <= cnt_nxt;
    end
  end

  // A writeback landing this cycle resolves the hazard when it is forwarded.
  always_comb begin
    rs1_busy_o = pending_q[rs1_addr_i] &
                 ~(BYPASS_EN && wr_en_i && (rd_addr_i == rs1_addr_i));
    rs2_busy_o = pending_q[rs2_addr_i] &
                 ~(BYPASS_EN && wr_en_i && (rd_addr_i == rs2_addr_i));
  end

endmodule

// File: rtl/kamus_regfile.sv
// kamus_regfile: 32 x XLEN integer register file with two combinational
// read ports, optional same-cycle write-to-read bypass and a pending-write
// scoreboard for decode stalls.
//   clk_i  - core clock, rising edge
//   rst_ni - asynchronous active-low reset
//   rf     - kamus_regfile_if.slave (write port, read ports, scoreboard)
module kamus_regfile
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = NUM_REGS,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  kamus_regfile_if.slave rf
);

  // x0 has no storage; the read muxes force it to zero.
  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (rf.regfile_wr_en_i && (rf.rd_addr_i != REG_X0)) begin
      regs[rf.rd_addr_i] <= rf.wb_data_i;
    end
  end

  always_comb begin
    rf.rs1_data_o = '0;
    if (rf.rs1_addr_i != REG_X0) begin
      if (BYPASS_EN && rf.regfile_wr_en_i && (rf.rd_addr_i == rf.rs1_addr_i))
        rf.rs1_data_o = rf.wb_data_i;
      else
        rf.rs1_data_o = regs[rf.rs1_addr_i];
    end
  end

  always_comb begin
    rf.rs2_data_o = '0;
    if (rf.rs2_addr_i != REG_X0) begin
      if (BYPASS_EN && rf.regfile_wr_en_i && (rf.rd_addr_i == rf.rs2_addr_i))
        rf.rs2_data_o = rf.wb_data_i;
      else
        rf.rs2_data_o = regs[rf.rs2_addr_i];
    end
  end

  kamus_scoreboard #(
    .NREGS     (NREGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_en_i    (rf.issue_en_i),
    .issue_rd_i    (rf.issue_rd_i),
    .wr_en_i       (rf.regfile_wr_en_i),
    .rd_addr_i     (rf.rd_addr_i),
    .flush_i       (rf.flush_i),
    .rs1_addr_i    (rf.rs1_addr_i),
    .rs2_addr_i    (rf.rs2_addr_i),
    .rs1_busy_o    (rf.rs1_busy_o),
    .rs2_busy_o    (rf.rs2_busy_o),
    .pending_cnt_o (rf.pending_cnt_o)
  );

endmodule

// File: tb/tb_kamus_regfile.sv
// tb_kamus_regfile: directed self-checking bench for kamus_regfile.
module tb_kamus_regfile;

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_fail;

  kamus_regfile_if #(.XLEN(32)) rf_if ();

  kamus_regfile #(
    .XLEN      (32),
    .NREGS     (32),
    .BYPASS_EN (1'b1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rf     (rf_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // well clear of it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rf_if.regfile_wr_en_i = 1'b0;
    rf_if.rd_addr_i       = '0;
    rf_if.wb_data_i       = '0;
    rf_if.issue_en_i      = 1'b0;
    rf_if.issue_rd_i      = '0;
    rf_if.flush_i         = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    idle();
    rf_if.rs1_addr_i = '0;
    rf_if.rs2_addr_i = '0;

    // Reset: every address reads zero, nothing busy
    #12;
    rst_ni = 1'b1;
    #1;
    chk("reset_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rf_if.rs1_addr_i = 5'(i);
      rf_if.rs2_addr_i = 5'(31 - i);
      #1;
      chk("reset_rs1", rf_if.rs1_data_o, 32'h0);
      chk("reset_rs2", rf_if.rs2_data_o, 32'h0);
      chk("reset_busy", {30'd0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'd0);
    end

    // Write x5 with same-cycle bypass, then read from the array
    step();
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd5;
    rf_if.wb_data_i       = 32'hDEAD_BEEF;
    rf_if.rs1_addr_i      = 5'd5;
    rf_if.rs2_addr_i      = 5'd6;
    #1;
    chk("bypass_x5", rf_if.rs1_data_o, 32'hDEAD_BEEF);
    chk("no_bypass_x6", rf_if.rs2_data_o, 32'h0);
    step();
    idle();
    #1;
    chk("array_x5", rf_if.rs1_data_o, 32'hDEAD_BEEF);

    // Write to x0 is discarded, never busy
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd0;
    rf_if.wb_data_i       = 32'h1234_5678;
    rf_if.rs1_addr_i      = 5'd0;
    rf_if.rs2_addr_i      = 5'd0;
    #1;
    chk("x0_bypass_rs1", rf_if.rs1_data_o, 32'h0);
    chk("x0_bypass_rs2", rf_if.rs2_data_o, 32'h0);
    step();
    idle();
    #1;
    chk("x0_rs1", rf_if.rs1_data_o, 32'h0);
    chk("x0_rs2", rf_if.rs2_data_o, 32'h0);
    chk("x0_busy", {30'd0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'd0);
    chk("x0_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);

    // Issue x7 -> busy next cycle; writeback clears busy immediately
    rf_if.issue_en_i = 1'b1;
    rf_if.issue_rd_i = 5'd7;
    rf_if.rs1_addr_i = 5'd7;
    #1;
    chk("issue7_busy_same", {31'd0, rf_if.rs1_busy_o}, 32'd0);
    step();
    idle();
    #1;
    chk("issue7_busy", {31'd0, rf_if.rs1_busy_o}, 32'd1);
    chk("issue7_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd1);
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd7;
    rf_if.wb_data_i       = 32'hA5A5_A5A5;
    #1;
    chk("wb7_busy", {31'd0, rf_if.rs1_busy_o}, 32'd0);
    chk("wb7_bypass", rf_if.rs1_data_o, 32'hA5A5_A5A5);
    chk("wb7_cnt_same", {26'd0, rf_if.pending_cnt_o}, 32'd1);
    step();
    idle();
    #1;
    chk("wb7_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    chk("wb7_array", rf_if.rs1_data_o, 32'hA5A5_A5A5);

    // Same-cycle issue and writeback of x9: issue wins
    rf_if.issue_en_i      = 1'b1;
    rf_if.issue_rd_i      = 5'd9;
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd9;
    rf_if.wb_data_i       = 32'h0909_0909;
    rf_if.rs2_addr_i      = 5'd9;
    step();
    idle();
    #1;
    chk("iw9_busy", {31'd0, rf_if.rs2_busy_o}, 32'd1);
    chk("iw9_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd1);
    chk("iw9_data", rf_if.rs2_data_o, 32'h0909_0909);
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd9;
    rf_if.wb_data_i       = 32'h9999_0000;
    step();
    idle();
    #1;
    chk("wb9_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    chk("wb9_busy", {31'd0, rf_if.rs2_busy_o}, 32'd0);

    // Issue x11, then issue x12 while x11 retires (different registers)
    rf_if.issue_en_i = 1'b1;
    rf_if.issue_rd_i = 5'd11;
    step();
    rf_if.issue_rd_i      = 5'd12;
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd11;
    rf_if.wb_data_i       = 32'h1111_1111;
    step();
    idle();
    rf_if.rs1_addr_i = 5'd11;
    rf_if.rs2_addr_i = 5'd12;
    #1;
    chk("mix_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd1);
    chk("mix_busy11", {31'd0, rf_if.rs1_busy_o}, 32'd0);
    chk("mix_busy12", {31'd0, rf_if.rs2_busy_o}, 32'd1);
    chk("mix_data11", rf_if.rs1_data_o, 32'h1111_1111);
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd12;
    rf_if.wb_data_i       = 32'h1212_1212;
    step();
    idle();
    #1;
    chk("mix_cnt_clr", {26'd0, rf_if.pending_cnt_o}, 32'd0);

    // Issue x3, x4, x6 back to back, then flush with a competing issue of x10
    rf_if.issue_en_i = 1'b1;
    rf_if.issue_rd_i = 5'd3;
    step();
    rf_if.issue_rd_i = 5'd4;
    step();
    rf_if.issue_rd_i = 5'd6;
    step();
    idle();
    rf_if.rs1_addr_i = 5'd3;
    rf_if.rs2_addr_i = 5'd6;
    #1;
    chk("three_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd3);
    chk("three_busy", {30'd0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'd3);
    rf_if.flush_i    = 1'b1;
    rf_if.issue_en_i = 1'b1;
    rf_if.issue_rd_i = 5'd10;
    step();
    idle();
    rf_if.rs1_addr_i = 5'd10;
    rf_if.rs2_addr_i = 5'd4;
    #1;
    chk("flush_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    chk("flush_busy", {30'd0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'd0);

    // Writeback to a non-pending register
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd20;
    rf_if.wb_data_i       = 32'hCAFE_F00D;
    step();
    idle();
    rf_if.issue_en_i = 1'b1;
    rf_if.issue_rd_i = 5'd15;
    rf_if.rs1_addr_i = 5'd20;
    #1;
    chk("np20_data", rf_if.rs1_data_o, 32'hCAFE_F00D);
    chk("np20_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    step();
    idle();
    #1;
    chk("pre_rst_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd1);

    // Asynchronous reset mid-write
    rf_if.regfile_wr_en_i = 1'b1;
    rf_if.rd_addr_i       = 5'd5;
    rf_if.wb_data_i       = 32'hFFFF_FFFF;
    rf_if.rs1_addr_i      = 5'd20;
    rf_if.rs2_addr_i      = 5'd7;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_x20", rf_if.rs1_data_o, 32'h0);
    chk("rst_x7", rf_if.rs2_data_o, 32'h0);
    chk("rst_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);
    @(posedge clk_i);
    #1;
    idle();
    rf_if.rs1_addr_i = 5'd5;
    #1;
    chk("rst_x5", rf_if.rs1_data_o, 32'h0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_x5", rf_if.rs1_data_o, 32'h0);
    chk("post_rst_x7", rf_if.rs2_data_o, 32'h0);
    chk("post_rst_busy", {30'd0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'd0);
    step();
    #1;
    chk("post_rst_cnt", {26'd0, rf_if.pending_cnt_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
